sine_wave_analyser: RTL and testbench
=====================================

# sine_wave_analyser

Receive-side counterpart to the sine sample generator: consumes a stream of unsigned sine samples and recovers the waveform's period, peak, trough and peak-to-peak amplitude, once per cycle. It sits downstream of a sample source, either the generator in loopback or an ADC capture path. It lets the design self-check generated waveforms and lock onto externally supplied ones.

## Interface
- `SAMPLE_WIDTH`, 8: sample and amplitude width, unsigned.
- `COUNT_WIDTH`, 16: period counter and output width.
- `TRAIN_LEN`, 128: valid samples used to establish the initial min/max; must exceed one expected period.
- `HYST`, 4: crossing hysteresis in LSBs about the midpoint.
- `MAX_PERIOD`, 1024: valid samples without a rising crossing before timeout.

Ports:
- `clock` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low; asserting it clears all state immediately.
- `sample_valid` in 1: qualifies `sample`; only valid samples advance any state.
- `sample` in SAMPLE_WIDTH: unsigned sine sample.
- `period` out COUNT_WIDTH: valid samples between the last two rising crossings.
- `peak` out SAMPLE_WIDTH: maximum sample in the last measured period.
- `trough` out SAMPLE_WIDTH: minimum sample in the last measured period.
- `amplitude` out SAMPLE_WIDTH: `peak - trough`.
- `result_valid` out 1: one-cycle pulse when the results update.
- `locked` out 1: high while consecutive periods are being measured.
- `timeout` out 1: one-cycle pulse when lock is lost or never achieved.

## Operation
- States are INIT, TRAIN and TRACK.
- INIT: the first valid sample loads `run_min` = `run_max` = `sample`, sets `cnt` = 1, then goes to TRAIN.
- TRAIN: each valid sample updates `run_min`/`run_max` and increments `cnt`.
  - When the sample making `cnt` = `TRAIN_LEN` is accepted: `mid` = (`run_min` + `run_max`) >> 1, computed with a SAMPLE_WIDTH+1 sum.
  - Also on that sample: `below` = 0, `first_edge` = 1, `cnt` = 0, run stats reload from that sample, then go to TRACK.
- TRACK, per valid sample:
  - `lo_th` = `mid - HYST`, saturating at 0; `hi_th` = `mid + HYST`, saturating at the maximum code.
  - `sample <= lo_th` sets `below`.
  - Rising crossing = `below` && `sample >= hi_th`; this clears `below`.
  - A non-crossing sample updates run stats and increments `cnt` (saturating).
  - First crossing after entering TRACK (`first_edge` = 1): synchronise only, with `cnt` = 0, `first_edge` = 0, run stats reload from the crossing sample. No result.
  - Later crossings:
    - `period` = `cnt` + 1.
    - `peak`/`trough` = run max/min including the crossing sample.
    - `amplitude` = `peak - trough`.
    - `result_valid` pulses and `locked` = 1.
    - `mid` is updated to (`peak` + `trough`) >> 1.
    - `cnt` = 0 and run stats reload from the crossing sample.
  - When `cnt` reaches `MAX_PERIOD` with no crossing: pulse `timeout`, `locked` = 0, go to INIT. Result registers hold their last values.
- A flat or tiny signal (swing < 2·`HYST` about `mid`) never crosses and therefore times out.
- With `sample_valid` low: state, counters and outputs hold; pulses deassert.
- The outputs `period`, `peak`, `trough` and `amplitude` change only with `result_valid`.

## Timing
- Reset values: `period`, `peak`, `trough` and `amplitude` are 0; `result_valid`, `locked` and `timeout` are 0; state is INIT, `mid` = 0, `cnt` = 0.
- All outputs are registered.
- A crossing sample accepted on edge k gives updated results and `result_valid` = 1 in the cycle after edge k, for exactly one cycle.
- `timeout` pulses in the cycle after the sample that makes `cnt` = `MAX_PERIOD`.
- First result: one TRAIN window, plus the samples up to the first crossing, plus one full period.
- Back-to-back valid samples are supported indefinitely; there is no backpressure.
- Reset asserted mid-period discards partial statistics. The first result after release follows the full INIT → TRAIN → TRACK sequence.

## Test plan
- Square wave, 32×200 then 32×40, continuous valid, defaults -> `mid` = 120, `period` = 64, `peak` = 200, `trough` = 40, `amplitude` = 160, `result_valid` every 64 cycles, `locked` = 1 after the second crossing.
- Same wave with `sample_valid` low every other cycle -> identical `period` = 64 (valid samples, not clocks); results hold between pulses.
- Constant 128 input -> no `result_valid`; `timeout` pulses 1024 samples after TRAIN ends; `locked` stays 0; returns to INIT.
- Locked square wave, then amplitude drops to 122/118 (below hysteresis) -> `timeout` after 1024 samples, `locked` = 0, last `period`/`amplitude` held.
- Reset pulled low at sample 40 of a period while locked -> all outputs read 0 immediately. After release, the first `result_valid` arrives only after 128 training samples plus sync.
- Generator loopback at a known step rate -> `period` equals the generator's traversal length; `peak`/`trough` equal the table's extreme entries.

Source files
------------

// File: rtl/sine_wave_analyser_if.sv
// Sample stream in, per-period waveform measurements out.
// The master side drives samples; the slave side is the analyser.
interface sine_wave_analyser_if #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int COUNT_WIDTH  = 16
);
    logic                    sample_valid;
    logic [SAMPLE_WIDTH-1:0] sample;
    logic [COUNT_WIDTH-1:0]  period;
    logic [SAMPLE_WIDTH-1:0] peak;
    logic [SAMPLE_WIDTH-1:0] trough;
    logic [SAMPLE_WIDTH-1:0] amplitude;
    logic                    result_valid;
    logic                    locked;
    logic                    timeout;

    modport master (
        output sample_valid, sample,
        input  period, peak, trough, amplitude, result_valid, locked, timeout
    );

    modport slave (
        input  sample_valid, sample,
        output period, peak, trough, amplitude, result_valid, locked, timeout
    );
endinterface

// File: rtl/sine_wave_analyser.sv
// Recovers period, peak, trough and amplitude of an unsigned sine stream by
// timing rising midpoint crossings with hysteresis; midpoint is trained first.
module sine_wave_analyser #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int COUNT_WIDTH  = 16,
    parameter int TRAIN_LEN    = 128,
    parameter int HYST         = 4,
    parameter int MAX_PERIOD   = 1024
) (
    input logic                clock,
    input logic                reset,
    sine_wave_analyser_if.slave bus
);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        TRAIN = 2'd1,
        TRACK = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SAMPLE_WIDTH-1:0] run_min, run_max, mid;
    logic [COUNT_WIDTH-1:0]  cnt;
    logic                    below, first_edge;
    logic [COUNT_WIDTH-1:0]  period_q;
    logic [SAMPLE_WIDTH-1:0] peak_q, trough_q, amplitude_q;
    logic                    result_valid_q, locked_q, timeout_q;

    logic [SAMPLE_WIDTH-1:0] run_min_n, run_max_n, mid_n;
    logic [COUNT_WIDTH-1:0]  cnt_n;
    logic                    below_n, first_edge_n;
    logic [COUNT_WIDTH-1:0]  period_n;
    logic [SAMPLE_WIDTH-1:0] peak_n, trough_n, amplitude_n;
    logic                    result_valid_n, locked_n, timeout_n;

    logic [SAMPLE_WIDTH-1:0] min_upd, max_upd, lo_th, hi_th;
    logic [SAMPLE_WIDTH:0]   mm_sum, hi_sum;
    logic [COUNT_WIDTH-1:0]  cnt_inc;
    logic                    crossing, train_done, period_end;

    always_comb begin
        min_upd    = (bus.sample < run_min) ? bus.sample : run_min;
        max_upd    = (bus.sample > run_max) ? bus.sample : run_max;
        mm_sum     = {1'b0, min_upd} + {1'b0, max_upd};
        cnt_inc    = (cnt == '1) ? cnt : cnt + COUNT_WIDTH'(1);
        lo_th      = (mid < SAMPLE_WIDTH'(HYST)) ? '0 : mid - SAMPLE_WIDTH'(HYST);
        hi_sum     = {1'b0, mid} + (SAMPLE_WIDTH + 1)'(HYST);
        hi_th      = hi_sum[SAMPLE_WIDTH] ? '1 : hi_sum[SAMPLE_WIDTH-1:0];
        crossing   = below && (bus.sample >= hi_th);
        train_done = (cnt_inc == COUNT_WIDTH'(TRAIN_LEN));
        period_end = (cnt_inc == COUNT_WIDTH'(MAX_PERIOD));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.sample_valid) begin
            case (state)
                INIT:    state_nxt = TRAIN;
                TRAIN:   if (train_done) state_nxt = TRACK;
                TRACK:   if (!crossing && period_end) state_nxt = INIT;
                default: state_nxt = INIT;
            endcase
        end
    end

    always_comb begin
        run_min_n      = run_min;
        run_max_n      = run_max;
        mid_n          = mid;
        cnt_n          = cnt;
        below_n        = below;
        first_edge_n   = first_edge;
        period_n       = period_q;
        peak_n         = peak_q;
        trough_n       = trough_q;
        amplitude_n    = amplitude_q;
        result_valid_n = 1'b0;
        locked_n       = locked_q;
        timeout_n      = 1'b0;
        if (bus.sample_valid) begin
            case (state)
                INIT: begin
                    run_min_n = bus.sample;
                    run_max_n = bus.sample;
                    cnt_n     = COUNT_WIDTH'(1);
                end
                TRAIN: begin
                    run_min_n = min_upd;
                    run_max_n = max_upd;
                    cnt_n     = cnt_inc;
                    if (train_done) begin
                        // Midpoint includes the final training sample
                        mid_n        = mm_sum[SAMPLE_WIDTH:1];
                        below_n      = 1'b0;
                        first_edge_n = 1'b1;
                        cnt_n        = '0;
                        run_min_n    = bus.sample;
                        run_max_n    = bus.sample;
                    end
                end
                TRACK: begin
                    if (crossing) begin
                        below_n   = 1'b0;
                        cnt_n     = '0;
                        run_min_n = bus.sample;
                        run_max_n = bus.sample;
                        if (first_edge) begin
                            first_edge_n = 1'b0;
                        end else begin
                            period_n       = cnt + COUNT_WIDTH'(1);
                            peak_n         = max_upd;
                            trough_n       = min_upd;
                            amplitude_n    = max_upd - min_upd;
                            result_valid_n = 1'b1;
                            locked_n       = 1'b1;
                            mid_n          = mm_sum[SAMPLE_WIDTH:1];
                        end
                    end else begin
                        if (bus.sample <= lo_th) below_n = 1'b1;
                        run_min_n = min_upd;
                        run_max_n = max_upd;
                        cnt_n     = cnt_inc;
                        if (period_end) begin
                            timeout_n = 1'b1;
                            locked_n  = 1'b0;
                            cnt_n     = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_min        <= '0;
            run_max        <= '0;
            mid            <= '0;
            cnt            <= '0;
            below          <= 1'b0;
            first_edge     <= 1'b0;
            period_q       <= '0;
            peak_q         <= '0;
            trough_q       <= '0;
            amplitude_q    <= '0;
            result_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            run_min        <= run_min_n;
            run_max        <= run_max_n;
            mid            <= mid_n;
            cnt            <= cnt_n;
            below          <= below_n;
            first_edge     <= first_edge_n;
            period_q       <= period_n;
            peak_q         <= peak_n;
            trough_q       <= trough_n;
            amplitude_q    <= amplitude_n;
            result_valid_q <= result_valid_n;
            locked_q       <= locked_n;
            timeout_q      <= timeout_n;
        end
    end

    assign bus.period       = period_q;
    assign bus.peak         = peak_q;
    assign bus.trough       = trough_q;
    assign bus.amplitude    = amplitude_q;
    assign bus.result_valid = result_valid_q;
    assign bus.locked       = locked_q;
    assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_sine_wave_analyser.sv
// Directed bench for sine_wave_analyser: expected results and timeouts are
// queued with their due cycle when the triggering sample is driven.
module tb_sine_wave_analyser;

    localparam int SW = 8;
    localparam int CW = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    sine_wave_analyser_if #(.SAMPLE_WIDTH(SW), .COUNT_WIDTH(CW)) bus ();

    sine_wave_analyser #(
        .SAMPLE_WIDTH(SW),
        .COUNT_WIDTH (CW),
        .TRAIN_LEN   (128),
        .HYST        (4),
        .MAX_PERIOD  (1024)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int unsigned   cyc;
        logic [CW-1:0] period;
        logic [SW-1:0] peak;
        logic [SW-1:0] trough;
        logic [SW-1:0] amp;
    } res_t;

    res_t        res_q[$];
    int unsigned to_q[$];
    int          compared   = 0;
    int          mismatched = 0;
    int unsigned cyc        = 0;

    logic [CW-1:0] exp_period = '0;
    logic [SW-1:0] exp_peak   = '0;
    logic [SW-1:0] exp_trough = '0;
    logic [SW-1:0] exp_amp    = '0;
    logic          exp_locked = 1'b0;

    logic [SW-1:0] sine_tab[16];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [SW-1:0] s);
        @(posedge clock);
        #1;
        bus.sample_valid = v;
        bus.sample       = s;
    endtask

    task automatic push_res(input logic [CW-1:0] p, input logic [SW-1:0] pk,
                            input logic [SW-1:0] tr, input logic [SW-1:0] a);
        res_t r;
        r.cyc = cyc + 1; r.period = p; r.peak = pk; r.trough = tr; r.amp = a;
        res_q.push_back(r);
    endtask

    task automatic push_to();
        to_q.push_back(cyc + 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"}, 32'(bus.period), 0);
        check({tag, "_peak"}, 32'(bus.peak), 0);
        check({tag, "_trough"}, 32'(bus.trough), 0);
        check({tag, "_amp"}, 32'(bus.amplitude), 0);
        check({tag, "_rv"}, 32'(bus.result_valid), 0);
        check({tag, "_locked"}, 32'(bus.locked), 0);
        check({tag, "_timeout"}, 32'(bus.timeout), 0);
    endtask

    // Asserted mid-cycle so the clear must not wait for a clock edge
    task automatic do_reset();
        @(posedge clock);
        #1;
        bus.sample_valid = 1'b0;
        reset      = 1'b0;
        exp_period = '0;
        exp_peak   = '0;
        exp_trough = '0;
        exp_amp    = '0;
        exp_locked = 1'b0;
        #2;
        check_all_zero("rst_imm");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [SW-1:0] square(input int i);
        return ((i % 64) < 32) ? 8'd200 : 8'd40;
    endfunction

    always @(negedge clock) begin
        logic rv_exp, to_exp;
        res_t r;
        rv_exp = 1'b0;
        to_exp = 1'b0;
        if (res_q.size() > 0 && res_q[0].cyc == cyc) begin
            r          = res_q.pop_front();
            rv_exp     = 1'b1;
            exp_period = r.period;
            exp_peak   = r.peak;
            exp_trough = r.trough;
            exp_amp    = r.amp;
            exp_locked = 1'b1;
        end
        if (to_q.size() > 0 && to_q[0] == cyc) begin
            void'(to_q.pop_front());
            to_exp     = 1'b1;
            exp_locked = 1'b0;
        end
        check("result_valid", 32'(bus.result_valid), 32'(rv_exp));
        check("timeout", 32'(bus.timeout), 32'(to_exp));
        check("period", 32'(bus.period), 32'(exp_period));
        check("peak", 32'(bus.peak), 32'(exp_peak));
        check("trough", 32'(bus.trough), 32'(exp_trough));
        check("amplitude", 32'(bus.amplitude), 32'(exp_amp));
        check("locked", 32'(bus.locked), 32'(exp_locked));
    end

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        sine_tab = '{8'd128, 8'd166, 8'd199, 8'd220, 8'd228, 8'd220, 8'd199, 8'd166,
                     8'd128, 8'd90,  8'd57,  8'd36,  8'd28,  8'd36,  8'd57,  8'd90};

        // Reset state
        #3;
        check_all_zero("reset");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;

        // Continuous square wave, then reset 40 samples into a locked period
        for (int i = 0; i < 424; i++) begin
            drive(1'b1, square(i));
            if (i >= 256 && i % 64 == 0) push_res(16'd64, 8'd200, 8'd40, 8'd160);
        end
        do_reset();

        // Same wave, valid every other cycle; idle samples carry junk values
        for (int i = 0; i <= 384; i++) begin
            drive(1'b1, square(i));
            if (i >= 256 && i % 64 == 0) push_res(16'd64, 8'd200, 8'd40, 8'd160);
            drive(1'b0, SW'(i * 7));
        end
        repeat (4) drive(1'b0, '0);
        do_reset();

        // Constant input times out, then a fresh training pass locks again
        for (int i = 0; i < 1152; i++) begin
            drive(1'b1, 8'd128);
            if (i == 1151) push_to();
        end
        for (int j = 0; j <= 256; j++) begin
            drive(1'b1, square(j));
            if (j == 256) push_res(16'd64, 8'd200, 8'd40, 8'd160);
        end
        repeat (4) drive(1'b0, '0);
        do_reset();

        // Lock, then the swing collapses inside the hysteresis band
        for (int i = 0; i <= 320; i++) begin
            drive(1'b1, square(i));
            if (i >= 256 && i % 64 == 0) push_res(16'd64, 8'd200, 8'd40, 8'd160);
        end
        for (int i = 321; i <= 1350; i++) begin
            drive(1'b1, ((i % 64) < 32) ? 8'd122 : 8'd118);
            if (i == 1344) push_to();
        end
        repeat (4) drive(1'b0, '0);
        do_reset();

        // Generator loopback: 16-entry table at step 1
        for (int i = 0; i <= 209; i++) begin
            drive(1'b1, sine_tab[i % 16]);
            if (i >= 161 && (i - 161) % 16 == 0) push_res(16'd16, 8'd228, 8'd28, 8'd200);
        end
        repeat (4) drive(1'b0, '0);

        check("pending_results", 32'(res_q.size()), 0);
        check("pending_timeouts", 32'(to_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
